// File: rtl/bridge_pkg.sv
// Shared types and default constants for the UART-to-I2C burst bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bridge_pkg;

    // Bridge control states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        ERROR     = 3'd5
    } state_t;

    localparam int          DEF_DATA_W      = 8;
    localparam int          DEF_ADDR_W      = 7;
    localparam int unsigned DEF_SLAVE_ADDR  = 32'h2A;
    localparam int          DEF_BURST_LEN   = 4;
    localparam int          DEF_FLUSH_CYC   = 100000;
    localparam int          DEF_TIMEOUT_CYC = 1000;

    // Width of a counter that must hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bridge_buf.sv
// Small synchronous FIFO holding the burst that is gathered before an I2C flush.
// Latency: a pushed byte is visible on head one cycle later when the FIFO was empty.
// Backpressure: pushes while full and pops while empty are ignored; clear empties it.
//
// Ports: clk/rst_n clock and async active-low reset; clear synchronous flush;
//        push/push_dat write side; pop read side; head oldest entry;
//        count occupancy; full/empty status flags.
module bridge_buf
    import bridge_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_BURST_LEN,
    localparam int CNT_W  = cnt_width(DEPTH),
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Pointer advance with wrap for depths that are not a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/uart_i2c_bridge.sv
// Drains a UART RX FIFO into bursts of I2C single-byte writes to a fixed slave.
// Latency: full burst launches ~3 cycles after the last pop; partial burst after FLUSH_CYC idle cycles.
// Backpressure: UART is popped only while idle with buffer room; I2C waits on i2c_ready with a launch timeout.
//
// Optional feature: define BRIDGE_ECHO_EN to echo every sent byte back on the UART TX side.
// Ports: clk_100MHz/reset_n clock and async active-low reset;
//        rx_empty/rx_data/rd_uart UART RX FIFO pop interface; wr_uart/tx_data UART TX echo;
//        i2c_addr/i2c_rw/i2c_data/i2c_enable/i2c_ready I2C master command interface;
//        busy burst in progress; err_timeout sticky launch timeout; sent_count bytes sent (wraps).
module uart_i2c_bridge
    import bridge_pkg::*;
#(
    parameter int          DATA_W      = DEF_DATA_W,
    parameter int          ADDR_W      = DEF_ADDR_W,
    parameter int unsigned SLAVE_ADDR  = DEF_SLAVE_ADDR,
    parameter int          BURST_LEN   = DEF_BURST_LEN,
    parameter int          FLUSH_CYC   = DEF_FLUSH_CYC,
    parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk_100MHz,
    input  logic              reset_n,
    input  logic              rx_empty,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rd_uart,
    output logic              wr_uart,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W-1:0] i2c_addr,
    output logic              i2c_rw,
    output logic [DATA_W-1:0] i2c_data,
    output logic              i2c_enable,
    input  logic              i2c_ready,
    output logic              busy,
    output logic              err_timeout,
    output logic [15:0]       sent_count
);

    localparam int          CNT_W     = cnt_width(BURST_LEN);
    localparam logic [31:0] SLAVE_VEC = 32'(SLAVE_ADDR);

    state_t             state;
    logic [31:0]        flush_cnt;
    logic [31:0]        tmo_cnt;

    logic               buf_push;
    logic               buf_pop;
    logic               buf_clear;
    logic [DATA_W-1:0]  buf_head;
    logic [CNT_W-1:0]   buf_count;
    logic               buf_full;
    logic               buf_empty;

    logic               flush_due;
    logic               take_byte;
    logic               done_byte;

    assign i2c_addr = SLAVE_VEC[ADDR_W-1:0];
    assign i2c_rw   = 1'b0;
    assign busy     = (state != IDLE);

    // A partial burst is flushed once the idle counter reaches its limit.
    assign flush_due = !buf_empty && (flush_cnt == 32'(FLUSH_CYC));

    // rd_uart is registered, so the cycle it is high the UART head is still the
    // byte already captured; skipping that cycle avoids taking it twice.
    assign take_byte = (state == IDLE) && !buf_full && !flush_due && !rx_empty && !rd_uart;

    assign done_byte = (state == WAIT_DONE) && i2c_ready;

    assign buf_push  = take_byte;
    assign buf_pop   = done_byte;
    assign buf_clear = (state == ERROR);

    bridge_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BURST_LEN)
    ) u_buf (
        .clk      (clk_100MHz),
        .rst_n    (reset_n),
        .clear    (buf_clear),
        .push     (buf_push),
        .push_dat (rx_data),
        .pop      (buf_pop),
        .head     (buf_head),
        .count    (buf_count),
        .full     (buf_full),
        .empty    (buf_empty)
    );

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            tmo_cnt     <= '0;
            sent_count  <= '0;
            err_timeout <= 1'b0;
            rd_uart     <= 1'b0;
            i2c_enable  <= 1'b0;
            i2c_data    <= '0;
        end else begin
            rd_uart    <= 1'b0;
            i2c_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (buf_full || flush_due) begin
                        flush_cnt <= '0;
                        state     <= FETCH;
                    end else if (take_byte) begin
                        rd_uart   <= 1'b1;
                        flush_cnt <= '0;
                    end else if (buf_empty) begin
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + 32'd1;
                    end
                end
                FETCH: begin
                    // i2c_data only changes here, so it holds through the transfer.
                    i2c_data <= buf_head;
                    state    <= LAUNCH;
                end
                LAUNCH: begin
                    if (i2c_ready) begin
                        i2c_enable <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (!i2c_ready) begin
                        state <= WAIT_DONE;
                    end else if (tmo_cnt >= 32'(TIMEOUT_CYC - 1)) begin
                        state <= ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                WAIT_DONE: begin
                    if (i2c_ready) begin
                        sent_count <= sent_count + 16'd1;
                        state      <= (buf_count > CNT_W'(1)) ? FETCH : IDLE;
                    end
                end
                ERROR: begin
                    // The buffer is cleared through buf_clear while in this state.
                    err_timeout <= 1'b1;
                    tmo_cnt     <= '0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BRIDGE_ECHO_EN
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            wr_uart <= 1'b0;
            tx_data <= '0;
        end else begin
            wr_uart <= done_byte;
            if (done_byte) begin
                tx_data <= i2c_data;
            end
        end
    end
`else
    assign wr_uart = 1'b0;
    assign tx_data = '0;
`endif

endmodule

// File: tb/tb_uart_i2c_bridge.sv
// Self-checking bench for uart_i2c_bridge: UART RX FIFO and I2C master models,
// a table of burst vectors, and hand-written timeout, reset and wrap sequences.
// Latency/backpressure: models respond on the falling clock edge.
module tb_uart_i2c_bridge;

    localparam int FLUSH = 50;
    localparam int TMO   = 1000;

    logic        clk_100MHz = 1'b0;
    logic        reset_n    = 1'b0;
    logic        rx_empty   = 1'b1;
    logic [7:0]  rx_data    = 8'h00;
    logic        rd_uart;
    logic        wr_uart;
    logic [7:0]  tx_data;
    logic [6:0]  i2c_addr;
    logic        i2c_rw;
    logic [7:0]  i2c_data;
    logic        i2c_enable;
    logic        i2c_ready  = 1'b1;
    logic        busy;
    logic        err_timeout;
    logic [15:0] sent_count;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_i2c_bridge #(
        .DATA_W      (8),
        .ADDR_W      (7),
        .SLAVE_ADDR  (32'h2A),
        .BURST_LEN   (4),
        .FLUSH_CYC   (FLUSH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_100MHz  (clk_100MHz),
        .reset_n     (reset_n),
        .rx_empty    (rx_empty),
        .rx_data     (rx_data),
        .rd_uart     (rd_uart),
        .wr_uart     (wr_uart),
        .tx_data     (tx_data),
        .i2c_addr    (i2c_addr),
        .i2c_rw      (i2c_rw),
        .i2c_data    (i2c_data),
        .i2c_enable  (i2c_enable),
        .i2c_ready   (i2c_ready),
        .busy        (busy),
        .err_timeout (err_timeout),
        .sent_count  (sent_count)
    );

    int         n_vec = 0;
    int         n_bad = 0;

    // Model state
    logic [7:0] q[$];
    int         cyc = 0;
    int         hold_len = 20;
    int         model_hold = 0;
    bit         stuck = 0;
    int         en_cnt = 0;
    int         en_cyc = 0;
    logic [7:0] en_dat[$];
    int         last_pop_cyc = 0;
    bit         pop_since_en = 0;
    int         lat_meas = -1;
    int         echo_cnt = 0;
    logic [7:0] echo_dat[$];
    int         rdy_rise_cyc = 0;
    int         echo_gap = -1;
    int         overlap_cnt = 0;

    always @(negedge clk_100MHz) begin
        cyc = cyc + 1;
        if (rd_uart) begin
            if (q.size() > 0) void'(q.pop_front());
            last_pop_cyc = cyc;
            pop_since_en = 1;
            if (busy) overlap_cnt = overlap_cnt + 1;
        end
        if (i2c_enable) begin
            en_cnt = en_cnt + 1;
            en_cyc = cyc;
            en_dat.push_back(i2c_data);
            if (pop_since_en) begin
                lat_meas     = cyc - last_pop_cyc;
                pop_since_en = 0;
            end
            if (!stuck) begin
                i2c_ready  = 1'b0;
                model_hold = hold_len - 1;
            end
        end else if (!i2c_ready) begin
            if (model_hold > 0) begin
                model_hold = model_hold - 1;
            end else begin
                i2c_ready    = 1'b1;
                rdy_rise_cyc = cyc;
            end
        end
        if (wr_uart) begin
            echo_cnt = echo_cnt + 1;
            echo_dat.push_back(tx_data);
            echo_gap = cyc - rdy_rise_cyc;
        end
        rx_empty = (q.size() == 0);
        rx_data  = (q.size() > 0) ? q[0] : 8'h00;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait until n enables past base have happened and the bridge is idle again.
    task automatic wait_idle(input string name, input int base, input int n, input int bound);
        bit ok;
        ok = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk_100MHz);
            if ((en_cnt - base) >= n && !busy && i2c_ready && q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_vec = n_vec + 1;
            n_bad = n_bad + 1;
            $display("FAIL %s: timed out after %0d cycles, enables seen %0d of %0d", name, bound, en_cnt - base, n);
        end
    endtask

    typedef struct {
        int         n;
        logic [7:0] d[8];
        int         hold;
        bit         lat_chk;
    } vec_t;

    localparam int NV = 6;
    vec_t vt[NV];

    int exp_sent = 0;

    initial begin
        int base;
        int echo_base;
        int t0;
        bit seen;

        vt[0].n = 4; vt[0].d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00}; vt[0].hold = 20; vt[0].lat_chk = 0;
        vt[1].n = 1; vt[1].d = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vt[1].hold = 20; vt[1].lat_chk = 1;
        vt[2].n = 1; vt[2].d = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vt[2].hold = 3;  vt[2].lat_chk = 1;
        vt[3].n = 2; vt[3].d = '{8'hC3, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vt[3].hold = 1;  vt[3].lat_chk = 1;
        vt[4].n = 6; vt[4].d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00}; vt[4].hold = 2;  vt[4].lat_chk = 1;
        vt[5].n = 3; vt[5].d = '{8'hFF, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vt[5].hold = 5;  vt[5].lat_chk = 1;

        // Reset state
        repeat (3) @(negedge clk_100MHz);
        chk("rst_busy",     32'(busy),        32'd0);
        chk("rst_rd_uart",  32'(rd_uart),     32'd0);
        chk("rst_enable",   32'(i2c_enable),  32'd0);
        chk("rst_i2c_data", 32'(i2c_data),    32'd0);
        chk("rst_sent",     32'(sent_count),  32'd0);
        chk("rst_err",      32'(err_timeout), 32'd0);
        chk("rst_wr_uart",  32'(wr_uart),     32'd0);
        chk("rst_tx_data",  32'(tx_data),     32'd0);
        chk("addr",         32'(i2c_addr),    32'h2A);
        chk("rw",           32'(i2c_rw),      32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_100MHz);

        // Table-driven bursts
        for (int v = 0; v < NV; v++) begin
            hold_len  = vt[v].hold;
            base      = en_cnt;
            echo_base = echo_cnt;
            en_dat.delete();
            echo_dat.delete();
            lat_meas  = -1;
            for (int i = 0; i < vt[v].n; i++) q.push_back(vt[v].d[i]);
            wait_idle($sformatf("v%0d_done", v), base, vt[v].n, 4000);
            exp_sent = exp_sent + vt[v].n;
            chk($sformatf("v%0d_enables", v), 32'(en_cnt - base), 32'(vt[v].n));
            for (int i = 0; i < vt[v].n; i++)
                chk($sformatf("v%0d_data%0d", v, i), 32'(en_dat[i]), 32'(vt[v].d[i]));
            chk($sformatf("v%0d_sent", v), 32'(sent_count), 32'(exp_sent));
            chk($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
            if (vt[v].lat_chk)
                chk($sformatf("v%0d_flush_lat_in_50_54(lat=%0d)", v, lat_meas),
                    32'((lat_meas >= 50) && (lat_meas <= 54)), 32'd1);
`ifdef BRIDGE_ECHO_EN
            chk($sformatf("v%0d_echo_cnt", v), 32'(echo_cnt - echo_base), 32'(vt[v].n));
            for (int i = 0; i < vt[v].n; i++)
                chk($sformatf("v%0d_echo%0d", v, i), 32'(echo_dat[i]), 32'(vt[v].d[i]));
            chk($sformatf("v%0d_echo_gap", v), 32'(echo_gap), 32'd1);
`else
            chk($sformatf("v%0d_no_echo", v), 32'(echo_cnt - echo_base), 32'd0);
            chk($sformatf("v%0d_tx_zero", v), 32'(tx_data), 32'd0);
`endif
        end
        chk("no_pop_while_busy", 32'(overlap_cnt), 32'd0);

        // Launch timeout: ready never drops after the enable
        stuck = 1;
        base  = en_cnt;
        q.push_back(8'h77);
        seen = 0;
        for (int k = 0; k < 1600; k++) begin
            @(negedge clk_100MHz);
            if (err_timeout) begin
                seen = 1;
                break;
            end
        end
        t0 = cyc - en_cyc;
        chk("tmo_err", 32'(seen), 32'd1);
        chk($sformatf("tmo_lat_in_999_1003(lat=%0d)", t0), 32'((t0 >= 999) && (t0 <= 1003)), 32'd1);
        chk("tmo_enables", 32'(en_cnt - base), 32'd1);
        repeat (100) @(negedge clk_100MHz);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_no_relaunch", 32'(en_cnt - base), 32'd1);
        chk("tmo_sent", 32'(sent_count), 32'(exp_sent));
        stuck = 0;
        hold_len = 4;
        base = en_cnt;
        en_dat.delete();
        q.push_back(8'h78);
        wait_idle("tmo_next_done", base, 1, 2000);
        exp_sent = exp_sent + 1;
        chk("tmo_next_data", 32'(en_dat[0]), 32'h78);
        chk("tmo_next_sent", 32'(sent_count), 32'(exp_sent));
        chk("tmo_err_sticky", 32'(err_timeout), 32'd1);

        // Reset during WAIT_DONE
        hold_len = 20;
        base = en_cnt;
        q.push_back(8'h3C);
        seen = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk_100MHz);
            if (en_cnt > base) begin
                seen = 1;
                break;
            end
        end
        chk("rstmid_launch", 32'(seen), 32'd1);
        repeat (5) @(negedge clk_100MHz);
        chk("rstmid_busy_before", 32'(busy), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rstmid_busy",     32'(busy),        32'd0);
        chk("rstmid_enable",   32'(i2c_enable),  32'd0);
        chk("rstmid_rd_uart",  32'(rd_uart),     32'd0);
        chk("rstmid_i2c_data", 32'(i2c_data),    32'd0);
        chk("rstmid_sent",     32'(sent_count),  32'd0);
        chk("rstmid_err",      32'(err_timeout), 32'd0);
        chk("rstmid_wr_uart",  32'(wr_uart),     32'd0);
        chk("rstmid_tx_data",  32'(tx_data),     32'd0);
        @(negedge clk_100MHz);
        reset_n = 1'b1;
        exp_sent = 0;
        repeat (200) @(negedge clk_100MHz);
        chk("rstmid_no_retry", 32'(en_cnt - base), 32'd1);
        chk("rstmid_idle", 32'(busy), 32'd0);
        chk("rstmid_sent_after", 32'(sent_count), 32'd0);

        // sent_count wrap from 16'hFFFF
        @(negedge clk_100MHz);
        force dut.sent_count = 16'hFFFF;
        @(negedge clk_100MHz);
        release dut.sent_count;
        hold_len = 2;
        base = en_cnt;
        en_dat.delete();
        q.push_back(8'h99);
        wait_idle("wrap_done", base, 1, 2000);
        chk("wrap_data", 32'(en_dat[0]), 32'h99);
        chk("wrap_sent", 32'(sent_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
